// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - UART command decoder driving register-file writes/reads and receiver config.
// Optional RX_CFG_CMD_EN enables the 0xCC receiver-configuration command.
module uart_rx_cmd_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [7:0] RX_P_Data,
  input  logic       RX_Data_valid,
  input  logic       RX_Parity_error,
  input  logic       RX_stop_error,
  output logic [4:0] Prescale,
  output logic       Parity_EN,
  output logic       Parity_type,
  output logic [3:0] RF_Address,
  output logic [7:0] RF_WrData,
  output logic       RF_WrEn,
  output logic       RF_RdEn,
  input  logic [7:0] RF_RdData,
  input  logic       RF_RdData_valid,
  output logic [7:0] TX_P_Data,
  output logic       TX_Data_valid,
  input  logic       TX_busy,
  output logic [7:0] Err_count
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
`ifdef RX_CFG_CMD_EN
    , CFG_DATA
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] err_q, err_d;
  logic [3:0] tmo_q, tmo_d;
  logic       err_inc;
  logic       rx_ok, rx_bad;

  assign rx_ok  = RX_Data_valid && !RX_Parity_error && !RX_stop_error;
  assign rx_bad = RX_Data_valid && (RX_Parity_error || RX_stop_error);

`ifdef RX_CFG_CMD_EN
  logic [4:0] prescale_q, prescale_d;
  logic       par_en_q, par_en_d;
  logic       par_type_q, par_type_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_valid_d = 1'b0;
    err_inc    = 1'b0;
`ifdef RX_CFG_CMD_EN
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_bad) err_inc = 1'b1;
        else if (rx_ok) begin
          case (RX_P_Data)
            8'hAA:   state_d = WR_ADDR;
            8'hBB:   state_d = RD_ADDR;
`ifdef RX_CFG_CMD_EN
            8'hCC:   state_d = CFG_DATA;
`endif
            default: state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (rx_bad) begin err_inc = 1'b1; state_d = IDLE; end
        else if (rx_ok) begin addr_d = RX_P_Data[3:0]; state_d = WR_DATA; end
      end
      WR_DATA: begin
        if (rx_bad) begin err_inc = 1'b1; state_d = IDLE; end
        else if (rx_ok) begin
          wr_data_d = RX_P_Data;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_bad) begin err_inc = 1'b1; state_d = IDLE; end
        else if (rx_ok) begin
          addr_d  = RX_P_Data[3:0];
          rd_en_d = 1'b1;
          tmo_d   = 4'd0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Bytes arriving while a read is outstanding are dropped, good or bad.
        if (RX_Data_valid) err_inc = 1'b1;
        if (RF_RdData_valid) begin
          tx_data_d = RF_RdData;
          state_d   = TX_SEND;
        end else if (tmo_q == 4'd14) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      TX_SEND: begin
        if (RX_Data_valid) err_inc = 1'b1;
        if (!TX_busy) begin
          tx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
`ifdef RX_CFG_CMD_EN
      CFG_DATA: begin
        if (rx_bad) begin err_inc = 1'b1; state_d = IDLE; end
        else if (rx_ok) begin
          // A 32x prescale cannot be encoded in five bits, so only 8 and 16 are accepted.
          if (RX_P_Data[4:0] == 5'd8 || RX_P_Data[4:0] == 5'd16) begin
            prescale_d = RX_P_Data[4:0];
            par_en_d   = RX_P_Data[5];
            par_type_d = RX_P_Data[6];
          end else begin
            err_inc = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      addr_q     <= 4'd0;
      wr_data_q  <= 8'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      err_q      <= 8'd0;
      tmo_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef RX_CFG_CMD_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prescale_q <= 5'd8;
      par_en_q   <= 1'b1;
      par_type_q <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
    end
  end

  assign Prescale    = prescale_q;
  assign Parity_EN   = par_en_q;
  assign Parity_type = par_type_q;
`else
  assign Prescale    = 5'd8;
  assign Parity_EN   = 1'b1;
  assign Parity_type = 1'b0;
`endif

  assign RF_Address    = addr_q;
  assign RF_WrData     = wr_data_q;
  assign RF_WrEn       = wr_en_q;
  assign RF_RdEn       = rd_en_q;
  assign TX_P_Data     = tx_data_q;
  assign TX_Data_valid = tx_valid_q;
  assign Err_count     = err_q;

endmodule
